// File: rtl/nway_ins_cache.sv
// N-way set-associative instruction cache with line refill from a wide memory port.
// Latency: hit responds 2 edges after rd_en is sampled; a miss adds the refill wait plus one RESP cycle.
// Backpressure: one request at a time; rd_en is only sampled in IDLE, and a refill waits on mem_rd_rdy.
module nway_ins_cache #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [31:0]                addr,
    input  logic                       flush,
    output logic                       rd_rdy,
    output logic [31:0]                inst,
    output logic [31:0]                mem_addr,
    output logic                       mem_rd_en,
    input  logic                       mem_rd_rdy,
    input  logic [32*LINE_WORDS-1:0]   mem_data,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                miss_cnt
);

    localparam int LW    = 32 * LINE_WORDS;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int LVLS  = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

    state_t state, state_nxt;

    logic [LW-1:0]    data_mem [WAYS][SETS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [SETS-1:0]  valid_q  [WAYS];
    logic [LRU_W-1:0] lru_q    [SETS];
    logic             flush_pend;
    logic [31:0]      req_addr;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic             hit_any;
    logic             have_inv;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic [LW-1:0]    hit_line;
    logic [31:0]      hit_word;
    logic [31:0]      fill_word;

    logic             rd_rdy_nxt;
    logic [31:0]      inst_nxt;
    logic             mem_rd_en_nxt;
    logic [31:0]      mem_addr_nxt;
    logic             hit_inc;
    logic             miss_inc;
    logic             fill_we;
    logic             accept;
    logic             flush_do;
    logic             lru_we;
    logic [WAY_W-1:0] lru_way;

    // Tree PLRU: node bit set means the eviction candidate lies in the right subtree.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] t);
        int node;
        node = 0;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + 1 + int'(t[node]);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] t,
                                                     input logic [WAY_W-1:0] w);
        logic [LRU_W-1:0] r;
        logic             dir;
        int               node;
        r    = t;
        node = 0;
        for (int l = 0; l < LVLS; l++) begin
            dir     = w[LVLS-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    assign req_off = req_addr[OFF_W-1:0];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[31 -: TAG_W];

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        have_inv = 1'b0;
        victim   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-index invalid way as the victim.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                have_inv = 1'b1;
                victim   = WAY_W'(w);
            end
        end
        if (!have_inv) begin
            victim = plru_victim(lru_q[req_idx]);
        end
    end

    assign hit_line  = data_mem[hit_way][req_idx];
    assign hit_word  = hit_line[{req_off, 5'd0} +: 32];
    assign fill_word = mem_data[{req_off, 5'd0} +: 32];

    always_comb begin
        state_nxt     = state;
        rd_rdy_nxt    = 1'b0;
        inst_nxt      = inst;
        mem_rd_en_nxt = mem_rd_en;
        mem_addr_nxt  = mem_addr;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        fill_we       = 1'b0;
        accept        = 1'b0;
        flush_do      = 1'b0;
        lru_we        = 1'b0;
        lru_way       = '0;
        case (state)
            IDLE: begin
                if (flush || flush_pend) begin
                    flush_do = 1'b1;
                end else if (rd_en) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    rd_rdy_nxt = 1'b1;
                    inst_nxt   = hit_word;
                    hit_inc    = 1'b1;
                    lru_we     = 1'b1;
                    lru_way    = hit_way;
                    state_nxt  = IDLE;
                end else begin
                    miss_inc      = 1'b1;
                    mem_rd_en_nxt = 1'b1;
                    mem_addr_nxt  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    state_nxt     = MISS;
                end
            end
            MISS: begin
                if (mem_rd_rdy) begin
                    fill_we       = 1'b1;
                    lru_we        = 1'b1;
                    lru_way       = victim;
                    mem_rd_en_nxt = 1'b0;
                    rd_rdy_nxt    = 1'b1;
                    inst_nxt      = fill_word;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rd_rdy     <= 1'b0;
            inst       <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            flush_pend <= 1'b0;
            req_addr   <= '0;
        end else begin
            state     <= state_nxt;
            rd_rdy    <= rd_rdy_nxt;
            inst      <= inst_nxt;
            mem_rd_en <= mem_rd_en_nxt;
            mem_addr  <= mem_addr_nxt;
            if (accept) begin
                req_addr <= addr;
            end
            if (hit_inc && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_inc && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (flush_do) begin
                flush_pend <= 1'b0;
            end else if (flush && state != IDLE) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= '0;
            end
        end else if (flush_do) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= '0;
            end
        end else begin
            if (fill_we) begin
                valid_q[victim][req_idx] <= 1'b1;
            end
            if (lru_we) begin
                lru_q[req_idx] <= plru_touch(lru_q[req_idx], lru_way);
            end
        end
    end

    // Line storage carries no reset; fill_we is low whenever reset holds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[victim][req_idx] <= mem_data;
            tag_mem[victim][req_idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_nway_ins_cache.sv
// Bench for nway_ins_cache at default parameters: table of fetches plus flush, reset and saturation sequences.
module tb_nway_ins_cache;

    localparam int LWB = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic [31:0]     addr;
    logic            flush;
    logic            rd_rdy;
    logic [31:0]     inst;
    logic [31:0]     mem_addr;
    logic            mem_rd_en;
    logic            mem_rd_rdy;
    logic [LWB-1:0]  mem_data;
    logic [31:0]     hit_cnt;
    logic [31:0]     miss_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        bit          miss;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    nway_ins_cache dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .addr      (addr),
        .flush     (flush),
        .rd_rdy    (rd_rdy),
        .inst      (inst),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rd_rdy(mem_rd_rdy),
        .mem_data  (mem_data),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LWB-1:0] line_of(input logic [31:0] la);
        logic [LWB-1:0] l;
        l = '0;
        if (la == 32'd0) begin
            l[63:0] = 64'hAAAABBBBCCCCDDDD;
        end else begin
            for (int k = 0; k < 16; k++) begin
                l[32*k +: 32] = la ^ 32'h5A5A0000 ^ 32'(k);
            end
        end
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [LWB-1:0] l;
        l = line_of({a[31:4], 4'h0});
        return l[32*a[3:0] +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] a, input bit exp_miss, input bit flush_mid, input string name);
        bit          got       = 1'b0;
        bit          miss_seen = 1'b0;
        int          edges     = 1;
        int          wait_cnt  = 0;
        logic [31:0] e;
        exp_q.push_back(word_of(a));
        addr  = a;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        while (!got && edges < 200) begin
            step();
            edges++;
            mem_rd_rdy = 1'b0;
            flush      = 1'b0;
            if (rd_rdy) begin
                got = 1'b1;
                e   = exp_q.pop_front();
                chk({name, " inst"}, inst, e);
            end else if (mem_rd_en) begin
                if (!miss_seen) begin
                    miss_seen = 1'b1;
                    chk({name, " mem_addr"}, mem_addr, {a[31:4], 4'h0});
                    if (flush_mid) flush = 1'b1;
                end
                wait_cnt++;
                if (wait_cnt == 3) begin
                    mem_data   = line_of(mem_addr);
                    mem_rd_rdy = 1'b1;
                end
            end
        end
        mem_rd_rdy = 1'b0;
        flush      = 1'b0;
        chk({name, " responded"}, 32'(got), 32'd1);
        chk({name, " miss"}, 32'(miss_seen), 32'(exp_miss));
        if (got && !exp_miss) chk({name, " latency"}, 32'(edges), 32'd2);
        if (!got) e = exp_q.pop_front();
        step();
        chk({name, " pulse"}, 32'(rd_rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_hits;
        int exp_misses;
        int seen;
        rst        = 1'b0;
        rd_en      = 1'b0;
        addr       = '0;
        flush      = 1'b0;
        mem_rd_rdy = 1'b0;
        mem_data   = '0;
        #2;
        chk("reset rd_rdy", 32'(rd_rdy), 32'd0);
        chk("reset inst", inst, 32'd0);
        chk("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset hit_cnt", hit_cnt, 32'd0);
        chk("reset miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Cold fill, sequential hits, then 2-way conflict/LRU sequence in set 0.
        vt.push_back('{32'h0, 1'b1});
        for (int i = 1; i < 16; i++) vt.push_back('{32'(i), 1'b0});
        vt.push_back('{32'h2000, 1'b1});
        vt.push_back('{32'h0000, 1'b0});
        vt.push_back('{32'h2000, 1'b0});
        vt.push_back('{32'h4000, 1'b1});
        vt.push_back('{32'h0000, 1'b1});
        vt.push_back('{32'h4000, 1'b0});
        vt.push_back('{32'h2000, 1'b1});
        vt.push_back('{32'h4000, 1'b0});
        vt.push_back('{32'h2003, 1'b0});
        vt.push_back('{32'h0000, 1'b1});
        vt.push_back('{32'h0010, 1'b1});
        vt.push_back('{32'h001F, 1'b0});

        exp_hits   = 0;
        exp_misses = 0;
        for (int i = 0; i < vt.size(); i++) begin
            do_req(vt[i].a, vt[i].miss, 1'b0, $sformatf("vec%0d@%h", i, vt[i].a));
            if (vt[i].miss) exp_misses++;
            else exp_hits++;
        end
        chk("table hit_cnt", hit_cnt, 32'(exp_hits));
        chk("table miss_cnt", miss_cnt, 32'(exp_misses));

        // Flush in IDLE wins over a simultaneous rd_en.
        addr  = 32'h001F;
        rd_en = 1'b1;
        flush = 1'b1;
        step();
        rd_en = 1'b0;
        flush = 1'b0;
        seen  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_rdy || mem_rd_en) seen++;
        end
        chk("idle flush ignores rd_en", 32'(seen), 32'd0);
        do_req(32'h001F, 1'b1, 1'b0, "after idle flush");

        // Flush during MISS: fill completes, then everything is invalid.
        do_req(32'h0020, 1'b1, 1'b1, "flush mid miss");
        step();
        do_req(32'h0020, 1'b1, 1'b0, "repeat after flush");
        do_req(32'h001F, 1'b1, 1'b0, "other after flush");

        // Reset while a refill is outstanding.
        addr  = 32'h0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        chk("pre-reset mem_rd_en", 32'(mem_rd_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("async reset mem_addr", mem_addr, 32'd0);
        chk("async reset hit_cnt", hit_cnt, 32'd0);
        chk("async reset miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b1;
        step();
        mem_data   = line_of(32'h0);
        mem_rd_rdy = 1'b1;
        step();
        mem_rd_rdy = 1'b0;
        chk("stale mem_rd_rdy rd_rdy", 32'(rd_rdy), 32'd0);
        step();
        chk("stale mem_rd_rdy miss_cnt", miss_cnt, 32'd0);
        do_req(32'h0, 1'b1, 1'b0, "miss after reset");

        // Hit counter saturation.
        force dut.hit_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.hit_cnt;
        do_req(32'h1, 1'b0, 1'b0, "sat hit1");
        chk("sat step", hit_cnt, 32'hFFFF_FFFE);
        do_req(32'h2, 1'b0, 1'b0, "sat hit2");
        do_req(32'h3, 1'b0, 1'b0, "sat hit3");
        chk("sat hold", hit_cnt, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
